// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph scroller: mode encodings, glyph indices
// and the procedural glyph bitmap function.
package glyph_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [1:0] GLYPH_BLANK = 2'd0;
    localparam logic [1:0] GLYPH_BOX   = 2'd1;
    localparam logic [1:0] GLYPH_X     = 2'd2;
    localparam logic [1:0] GLYPH_CHECK = 2'd3;

    // Bitmaps are computed from (r, c) so any legal edge length works.
    function automatic logic glyph_pixel(input logic [1:0] glyph, input int r,
                                         input int c, input int size);
        int d1;
        int d2;
        d1 = r - c;
        if (d1 < 0) d1 = -d1;
        d2 = r + c - (size - 1);
        if (d2 < 0) d2 = -d2;
        case (glyph)
            GLYPH_BOX:   glyph_pixel = (r == 0) || (c == 0) || (r == size - 1) || (c == size - 1);
            GLYPH_X:     glyph_pixel = (d1 <= 1) || (d2 <= 1);
            GLYPH_CHECK: glyph_pixel = r[0] ^ c[0];
            default:     glyph_pixel = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/glyph_anim.sv
// Animation timing: divides frame_start pulses into steps that advance the
// scroll offset or toggle the blink phase.
module glyph_anim
    import glyph_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int TICK_DIV = 4,
    parameter int AW       = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          activate,
    input  mode_e         mode,
    output logic [AW-1:0] offset,
    output logic          blink_vis
);

    logic [7:0]    tick_q, tick_d;
    logic [AW-1:0] offset_q, offset_d;
    logic          vis_q, vis_d;
    logic          step;

    always_comb begin
        tick_d   = tick_q;
        offset_d = offset_q;
        vis_d    = vis_q;
        step     = 1'b0;
        // A frame_start that activates a new selection restarts the animation.
        if (activate) begin
            tick_d   = '0;
            offset_d = '0;
            vis_d    = 1'b1;
        end else if (frame_start) begin
            if (tick_q == 8'(TICK_DIV - 1)) begin
                tick_d = '0;
                step   = 1'b1;
            end else begin
                tick_d = tick_q + 8'd1;
            end
            if (step && mode == MODE_SCROLL)
                offset_d = (offset_q == AW'(SIZE - 1)) ? '0 : offset_q + AW'(1);
            if (step && mode == MODE_BLINK)
                vis_d = ~vis_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q   <= '0;
            offset_q <= '0;
            vis_q    <= 1'b1;
        end else begin
            tick_q   <= tick_d;
            offset_q <= offset_d;
            vis_q    <= vis_d;
        end
    end

    assign offset    = offset_q;
    assign blink_vis = vis_q;

endmodule

// File: rtl/glyph_scroll.sv
// Glyph renderer: a request is parked in a pending slot, becomes active at
// the next frame_start, and the queried pixel is returned one cycle later.
module glyph_scroll
    import glyph_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int TICK_DIV = 4,
    parameter int AW       = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [AW-1:0] row,
    input  logic [AW-1:0] col,
    input  logic          sel_valid,
    input  logic [1:0]    sel_glyph,
    input  logic [1:0]    sel_mode,
    output logic          sel_ready,
    output logic          pixel,
    output logic [AW-1:0] offset
);

    logic [1:0]    act_glyph_q, act_glyph_d;
    logic [1:0]    pend_glyph_q, pend_glyph_d;
    mode_e         act_mode_q, act_mode_d;
    mode_e         pend_mode_q, pend_mode_d;
    logic          sel_ready_q, sel_ready_d;
    logic          pixel_q, pixel_d;
    logic          accept, activate, blink_vis, glyph_bit;
    logic [AW-1:0] anim_offset, col_eff;
    logic [AW:0]   col_sum;

    // sel_ready low means a request is pending; the next frame_start consumes it.
    assign accept   = sel_valid && sel_ready_q;
    assign activate = frame_start && !sel_ready_q;

    glyph_anim #(
        .SIZE     (SIZE),
        .TICK_DIV (TICK_DIV),
        .AW       (AW)
    ) u_anim (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .activate    (activate),
        .mode        (act_mode_q),
        .offset      (anim_offset),
        .blink_vis   (blink_vis)
    );

    always_comb begin
        pend_glyph_d = pend_glyph_q;
        pend_mode_d  = pend_mode_q;
        act_glyph_d  = act_glyph_q;
        act_mode_d   = act_mode_q;
        sel_ready_d  = sel_ready_q;
        if (accept) begin
            pend_glyph_d = sel_glyph;
            pend_mode_d  = mode_e'(sel_mode);
            sel_ready_d  = 1'b0;
        end else if (activate) begin
            act_glyph_d = pend_glyph_q;
            act_mode_d  = pend_mode_q;
            sel_ready_d = 1'b1;
        end
    end

    always_comb begin
        col_sum = {1'b0, col} + {1'b0, anim_offset};
        col_eff = col;
        if (act_mode_q == MODE_SCROLL)
            col_eff = (col_sum >= (AW+1)'(SIZE)) ? AW'(col_sum - (AW+1)'(SIZE)) : col_sum[AW-1:0];
        glyph_bit = glyph_pixel(act_glyph_q, int'(row), int'(col_eff), SIZE);
        case (act_mode_q)
            MODE_OFF:   pixel_d = 1'b0;
            MODE_BLINK: pixel_d = glyph_bit && blink_vis;
            default:    pixel_d = glyph_bit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_glyph_q  <= GLYPH_BLANK;
            pend_glyph_q <= GLYPH_BLANK;
            act_mode_q   <= MODE_OFF;
            pend_mode_q  <= MODE_OFF;
            sel_ready_q  <= 1'b1;
            pixel_q      <= 1'b0;
        end else begin
            act_glyph_q  <= act_glyph_d;
            pend_glyph_q <= pend_glyph_d;
            act_mode_q   <= act_mode_d;
            pend_mode_q  <= pend_mode_d;
            sel_ready_q  <= sel_ready_d;
            pixel_q      <= pixel_d;
        end
    end

    assign sel_ready = sel_ready_q;
    assign pixel     = pixel_q;
    assign offset    = anim_offset;

endmodule
